// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_min transmitter among NREQ byte sources.
// Each grant is a one-cycle write/ack, followed by a locally timed frame gap.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int FRAME_CYCLES = 4340
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                en,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     ack,
    output logic                tx_write,
    output logic [7:0]          tx_data,
    output logic                busy,
    output logic [1:0]          state,
    output logic [15:0]         tx_count
);

    localparam int GW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [GW-1:0]      r_gap;
    logic [IW-1:0]      r_last;
    logic [NREQ-1:0]    r_ack;
    logic               r_write;
    logic [7:0]         r_data;
    logic               r_busy;
    logic [15:0]        r_count;

    logic [7:0]         w_bytes [NREQ];
    logic               w_found;
    logic [IW-1:0]      w_idx;
    logic [NREQ-1:0]    w_onehot;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
            assign w_bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Scan offsets from farthest to nearest so the requester closest after r_last wins.
    always_comb begin : arb
        int pos;
        pos     = 0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int off = NREQ; off >= 1; off--) begin
            pos = (int'(r_last) + off) % NREQ;
            if (req[pos]) begin
                w_found = 1'b1;
                w_idx   = IW'(pos);
            end
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
            r_last  <= IW'(NREQ - 1);
            r_ack   <= '0;
            r_write <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
        end else begin
            r_write <= 1'b0;
            r_ack   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (en && w_found) begin
                        r_state <= S_WRITE;
                        r_write <= 1'b1;
                        r_ack   <= w_onehot;
                        r_data  <= w_bytes[w_idx];
                        r_last  <= w_idx;
                        r_busy  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state <= S_GAP;
                    r_gap   <= GW'(FRAME_CYCLES - 1);
                    r_count <= r_count + 16'd1;
                end
                S_GAP: begin
                    // Leaving at zero keeps the gap at exactly FRAME_CYCLES and never wraps the counter.
                    if (r_gap == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign tx_write = r_write;
    assign tx_data  = r_data;
    assign busy     = r_busy;
    assign state    = r_state;
    assign tx_count = r_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a cycle-timeline reference model predicts grants,
// a monitor process checks every DUT cycle and every write pulse against it.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int F    = 20;

    localparam int P_HOLD = 0;
    localparam int P_DROP = 1;
    localparam int P_RAND = 2;

    logic                clk = 1'b0;
    logic                clr_n = 1'b0;
    logic                en = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [8*NREQ-1:0]   req_data = '0;
    logic [NREQ-1:0]     ack;
    logic                tx_write;
    logic [7:0]          tx_data;
    logic                busy;
    logic [1:0]          state;
    logic [15:0]         tx_count;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .FRAME_CYCLES(F)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (en),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_write (tx_write),
        .tx_data  (tx_data),
        .busy     (busy),
        .state    (state),
        .tx_count (tx_count)
    );

    typedef struct {
        longint     edge_n;
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t        q[$];
    int          compared = 0;
    int          mismatched = 0;
    longint      cyc = 0;
    int          policy = P_DROP;

    // Reference model: a grant may happen at any edge at or after m_next_ok.
    int          m_last = NREQ - 1;
    longint      m_next_ok = 0;
    longint      m_g = -1000;
    int          m_gidx = 0;
    logic [15:0] m_cnt = '0;
    logic [7:0]  m_data = '0;
    int          n_grants = 0;
    exp_t        m_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        int win;
        if (!clr_n) begin
            m_last    = NREQ - 1;
            m_next_ok = 0;
            m_g       = -1000;
            m_cnt     = '0;
            m_data    = '0;
        end else if (cyc >= m_next_ok && en && (req != '0)) begin
            win = -1;
            for (int off = 1; off <= NREQ; off++)
                if (win < 0 && req[(m_last + off) % NREQ]) win = (m_last + off) % NREQ;
            m_e.edge_n = cyc;
            m_e.idx    = win;
            m_e.data   = req_data[8*win +: 8];
            q.push_back(m_e);
            m_last    = win;
            m_next_ok = cyc + F + 2;
            m_g       = cyc;
            m_gidx    = win;
            m_data    = m_e.data;
            m_cnt     = m_cnt + 16'd1;
            n_grants++;
        end
        cyc++;
    end

    // Monitor: samples 1 ns after each rising edge.
    initial begin
        longint          m;
        int              es;
        int              run;
        longint          last_wr;
        exp_t            e;
        logic [15:0]     ecnt;
        logic [NREQ-1:0] eack;
        run     = 0;
        last_wr = -1000;
        forever begin
            @(posedge clk);
            #1;
            m  = cyc - 1;
            es = (m == m_g) ? 1 : ((m > m_g && m <= m_g + F) ? 2 : 0);
            ecnt = (m == m_g) ? m_cnt - 16'd1 : m_cnt;
            chk("state_busy_write", {state, busy, tx_write}, {es[1:0], es != 0, es == 1});
            chk("tx_count", tx_count, ecnt);
            chk("tx_data_hold", tx_data, m_data);
            if (!clr_n) begin
                run = 0;
                last_wr = -1000;
            end else if (busy) begin
                run++;
            end else begin
                if (run > 0) chk("busy_len", run, F + 1);
                run = 0;
            end
            if (tx_write || ack != '0) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", {tx_write, ack}, '0);
                end else begin
                    e = q.pop_front();
                    eack = '0;
                    eack[e.idx] = 1'b1;
                    chk("write_cycle", m, e.edge_n);
                    chk("write_strobe", tx_write, 1'b1);
                    chk("ack_onehot", ack, eack);
                    chk("write_data", tx_data, e.data);
                    if (last_wr > 0) chk("write_spacing_min", (m - last_wr) >= F + 2, 1'b1);
                    last_wr = m;
                    $display("tx cycle %0d: requester %0d data 0x%02h ack %b count %0d",
                             m, e.idx, tx_data, ack, tx_count);
                end
            end
        end
    end

    // Advance to the next falling edge and let the requester just served respond.
    task automatic tick();
        int i;
        @(negedge clk);
        if (clr_n && m_g == cyc - 1) begin
            i = m_gidx;
            if (policy == P_DROP) req[i] = 1'b0;
            else if (policy == P_RAND) begin
                if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                else req_data[8*i +: 8] = 8'($urandom);
            end
        end
    endtask

    task automatic wait_grants(input int n, input int lim, input string name);
        int target;
        int i;
        target = n_grants + n;
        i = 0;
        while (i < lim && n_grants < target) begin
            tick();
            i++;
        end
        chk(name, n_grants >= target, 1'b1);
    endtask

    task automatic check_reset(input string name);
        chk(name, {ack, tx_write, tx_data, busy, state, tx_count}, '0);
    endtask

    initial begin
        repeat (3) tick();
        check_reset("reset_state");
        clr_n = 1'b1;
        en    = 1'b1;
        tick();

        // Single request.
        policy = P_DROP;
        req_data[7:0] = 8'h9B;
        req = 4'b0001;
        wait_grants(1, 3, "single_grant");
        repeat (F + 4) tick();
        chk("single_count", tx_count, 16'd1);

        // All requesting continuously: rotating order, back-to-back pacing.
        policy   = P_HOLD;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        req      = 4'b1111;
        wait_grants(8, 8 * (F + 2) + 10, "all_req_grants");
        policy = P_DROP;
        req    = '0;
        repeat (F + 4) tick();

        // After requester 2, search wraps from 3 to 0.
        req_data[23:16] = 8'h5A;
        req = 4'b0100;
        wait_grants(1, 3, "req2_grant");
        req_data[7:0]   = 8'hA5;
        req_data[23:16] = 8'h5B;
        req = 4'b0101;
        wait_grants(2, 3 * (F + 2), "wrap_grants");
        repeat (F + 4) tick();

        // Enable low blocks grants; enable high grants within one cycle.
        en = 1'b0;
        req_data[15:8] = 8'h77;
        req = 4'b0010;
        repeat (100) tick();
        en = 1'b1;
        wait_grants(1, 1, "en_rise_grant");

        // Enable dropped during the gap: frame completes, then park.
        repeat (F + 4) tick();
        req_data[31:24] = 8'hC3;
        req = 4'b1000;
        wait_grants(1, 3, "pre_en_drop_grant");
        repeat (5) tick();
        en = 1'b0;
        req_data[7:0] = 8'h3C;
        req = 4'b0001;
        repeat (F + 20) tick();
        en = 1'b1;
        wait_grants(1, 1, "en_resume_grant");

        // Reset in the middle of the gap, then requester 0 must win first.
        repeat (F - 10) tick();
        clr_n = 1'b0;
        #1;
        check_reset("reset_mid_gap");
        req = '0;
        tick();
        tick();
        clr_n = 1'b1;
        req_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        req = 4'b1111;
        wait_grants(4, 4 * (F + 2) + 10, "post_reset_grants");

        // Reset during the write cycle: byte lost, count stays 0.
        repeat (F + 4) tick();
        req_data[15:8] = 8'hE7;
        req = 4'b0010;
        wait_grants(1, 3, "pre_reset_write_grant");
        clr_n = 1'b0;
        #1;
        check_reset("reset_mid_write");
        req = '0;
        tick();
        tick();
        clr_n = 1'b1;
        tick();

        // Randomised traffic, including unserved drops and enable toggling.
        policy = P_RAND;
        for (int t = 0; t < 4000; t++) begin
            tick();
            if ($urandom_range(63, 0) == 0) en = ~en;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(7, 0) == 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(79, 0) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end

        policy = P_DROP;
        req = '0;
        en  = 1'b1;
        repeat (F + 6) tick();
        chk("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
